// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline.
// Generates the PC / IF/ID load enables, the IF flush, the ID-stage stall and
// flush selects, and the whole-pipe hold used while the data memory is busy.
// Three events are handled: load-use (one bubble), redirects resolved in EX
// (1 + REDIRECT_BUBBLES flush cycles) and data-memory wait states (freeze,
// with a sticky timeout flag and a stall-cycle counter).
module pipe_hazard_ctrl #(
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter int unsigned MEM_TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        idex_mem_read,
  input  logic [4:0]  idex_rd,
  input  logic [4:0]  ifid_rs1,
  input  logic [4:0]  ifid_rs2,
  input  logic        ifid_use_rs1,
  input  logic        ifid_use_rs2,
  input  logic        ex_redirect,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        if_flush,
  output logic        stall,
  output logic        id_flush,
  output logic        pipe_hold,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0]  BUBBLES = 3'(REDIRECT_BUBBLES);
  localparam logic [15:0] WAIT_MAX = 16'(MEM_TIMEOUT);

  state_t      state;
  state_t      ret_state;
  state_t      eff_state;
  logic [2:0]  bcnt;
  logic [15:0] wcnt;
  logic [15:0] wcnt_nxt;
  logic        mw;
  logic        lu;
  logic        rs1_hit;
  logic        rs2_hit;

  // Saturating increment for the wait counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v,
                                            input logic [15:0] lim);
    sat_inc16 = (v >= lim) ? lim : v + 16'd1;
  endfunction

  // Saturating increment for the performance counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    sat_inc32 = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Hazard detection and the state the release cycle behaves as.
  always_comb begin
    mw       = dmem_req & ~dmem_ready;
    rs1_hit  = ifid_use_rs1 & (ifid_rs1 == idex_rd);
    rs2_hit  = ifid_use_rs2 & (ifid_rs2 == idex_rd);
    lu       = idex_mem_read & (idex_rd != 5'd0) & (rs1_hit | rs2_hit);
    wcnt_nxt = sat_inc16(wcnt, WAIT_MAX);
    // While frozen, the controller acts as the state it left; ret_state is
    // only ever RUN or REDIRECT.
    eff_state = (state == MEM_WAIT) ? ret_state : state;
  end

  // Output decode: reset force, then mw > ex_redirect > REDIRECT > load-use.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    if_flush   = 1'b0;
    stall      = 1'b0;
    id_flush   = 1'b0;
    pipe_hold  = 1'b0;
    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      if_flush   = 1'b1;
      id_flush   = 1'b1;
    end else if (mw) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (ex_redirect) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (eff_state == REDIRECT) begin
      // ID already holds a bubble, so load-use is irrelevant here.
      if_flush = 1'b1;
    end else if (lu) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      stall      = 1'b1;
    end
  end

  // Sequencing state, bubble and wait counters, sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      ret_state   <= RUN;
      bcnt        <= 3'd0;
      wcnt        <= 16'd0;
      mem_timeout <= 1'b0;
    end else if (mw) begin
      // Freeze: remember where we came from; ex_redirect is not latched
      // because EX is held and will present it again on release.
      state <= MEM_WAIT;
      if (state != MEM_WAIT) begin
        ret_state <= state;
      end
      wcnt <= wcnt_nxt;
      if (wcnt_nxt == WAIT_MAX) begin
        mem_timeout <= 1'b1;
      end
    end else begin
      wcnt <= 16'd0;
      if (ex_redirect) begin
        if (BUBBLES != 3'd0) begin
          state <= REDIRECT;
          bcnt  <= BUBBLES;
        end else begin
          state <= RUN;
        end
      end else if (eff_state == REDIRECT) begin
        bcnt <= bcnt - 3'd1;
        if (bcnt == 3'd1) begin
          state <= RUN;
        end else begin
          state <= REDIRECT;
        end
      end else begin
        state <= RUN;
      end
    end
  end

  // Count every cycle in which the PC does not advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'd0;
    end else if (!pc_write) begin
      stall_cycles <= sat_inc32(stall_cycles);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (REDIRECT_BUBBLES=2, MEM_TIMEOUT=3).
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        idex_mem_read;
  logic [4:0]  idex_rd;
  logic [4:0]  ifid_rs1;
  logic [4:0]  ifid_rs2;
  logic        ifid_use_rs1;
  logic        ifid_use_rs2;
  logic        ex_redirect;
  logic        dmem_req;
  logic        dmem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        if_flush;
  logic        stall;
  logic        id_flush;
  logic        pipe_hold;
  logic        mem_timeout;
  logic [31:0] stall_cycles;
  logic [5:0]  outs;

  int total = 0;
  int bad   = 0;

  // {pc_write, ifid_write, if_flush, id_flush, stall, pipe_hold}
  assign outs = {pc_write, ifid_write, if_flush, id_flush, stall, pipe_hold};

  pipe_hazard_ctrl #(
    .REDIRECT_BUBBLES(2),
    .MEM_TIMEOUT(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .idex_mem_read(idex_mem_read),
    .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1),
    .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1),
    .ifid_use_rs2(ifid_use_rs2),
    .ex_redirect(ex_redirect),
    .dmem_req(dmem_req),
    .dmem_ready(dmem_ready),
    .pc_write(pc_write),
    .ifid_write(ifid_write),
    .if_flush(if_flush),
    .stall(stall),
    .id_flush(id_flush),
    .pipe_hold(pipe_hold),
    .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    idex_mem_read = 1'b0;
    idex_rd       = 5'd0;
    ifid_rs1      = 5'd0;
    ifid_rs2      = 5'd0;
    ifid_use_rs1  = 1'b0;
    ifid_use_rs2  = 1'b0;
    ex_redirect   = 1'b0;
    dmem_req      = 1'b0;
    dmem_ready    = 1'b0;
  endtask

  task automatic set_lu();
    idex_mem_read = 1'b1;
    idex_rd       = 5'd5;
    ifid_rs2      = 5'd5;
    ifid_use_rs2  = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    idex_mem_read = 1'($urandom);
    idex_rd       = 5'($urandom);
    ifid_rs1      = 5'($urandom);
    ifid_rs2      = 5'($urandom);
    ifid_use_rs1  = 1'($urandom);
    ifid_use_rs2  = 1'($urandom);
    ex_redirect   = 1'($urandom);
    dmem_req      = 1'($urandom);
    dmem_ready    = 1'($urandom);
    #2;
    total++;
    if (outs !== 6'b001100) begin
      bad++;
      $display("FAIL reset_outs got=%b want=%b", outs, 6'b001100);
    end
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d want=0", stall_cycles);
    end
    total++;
    if (mem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_timeout got=%b want=0", mem_timeout);
    end
    tick();
    idle();
    #1;
    rst_n = 1'b1;
    #2;
    total++;
    if (outs !== 6'b110000) begin
      bad++;
      $display("FAIL release_outs got=%b want=%b", outs, 6'b110000);
    end
    tick();
    total++;
    if (stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL release_cnt got=%0d want=0", stall_cycles);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_lu();
    #2;
    total++;
    if (outs !== 6'b000010) begin
      bad++;
      $display("FAIL lu_stall got=%b want=%b", outs, 6'b000010);
    end
    tick();
    idle();
    #2;
    total++;
    if (outs !== 6'b110000) begin
      bad++;
      $display("FAIL lu_after got=%b want=%b", outs, 6'b110000);
    end
    total++;
    if (stall_cycles !== 32'd1) begin
      bad++;
      $display("FAIL lu_cnt got=%0d want=1", stall_cycles);
    end
    tick();
    idex_mem_read = 1'b1;
    idex_rd       = 5'd0;
    ifid_rs2      = 5'd0;
    ifid_use_rs2  = 1'b1;
    #2;
    total++;
    if (outs !== 6'b110000) begin
      bad++;
      $display("FAIL lu_rd0 got=%b want=%b", outs, 6'b110000);
    end
    tick();
    idle();
    idex_mem_read = 1'b1;
    idex_rd       = 5'd7;
    ifid_rs1      = 5'd7;
    ifid_use_rs1  = 1'b1;
    #2;
    total++;
    if (outs !== 6'b000010) begin
      bad++;
      $display("FAIL lu_rs1 got=%b want=%b", outs, 6'b000010);
    end
    tick();
    ifid_use_rs1 = 1'b0;
    #2;
    total++;
    if (outs !== 6'b110000) begin
      bad++;
      $display("FAIL lu_nouse got=%b want=%b", outs, 6'b110000);
    end
    tick();
    ifid_use_rs1  = 1'b1;
    idex_mem_read = 1'b0;
    #2;
    total++;
    if (outs !== 6'b110000) begin
      bad++;
      $display("FAIL lu_noload got=%b want=%b", outs, 6'b110000);
    end
    tick();
    idle();
    total++;
    if (stall_cycles !== 32'd2) begin
      bad++;
      $display("FAIL lu_cnt2 got=%0d want=2", stall_cycles);
    end
  endtask

  task automatic test_redirect();
    // redirect pulse with a load-use pattern held throughout
    logic       redir_a [0:4];
    logic [5:0] exp_a   [0:4];
    // redirect reloaded while still flushing
    logic       redir_b [0:5];
    logic [5:0] exp_b   [0:5];
    redir_a = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_a   = '{6'b111100, 6'b111000, 6'b111000, 6'b000010, 6'b110000};
    redir_b = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_b   = '{6'b111100, 6'b111000, 6'b111100, 6'b111000, 6'b111000, 6'b110000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      idle();
      if (i < 4) set_lu();
      ex_redirect = redir_a[i];
      #2;
      total++;
      if (outs !== exp_a[i]) begin
        bad++;
        $display("FAIL redir_lu[%0d] got=%b want=%b", i, outs, exp_a[i]);
      end
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      idle();
      ex_redirect = redir_b[i];
      #2;
      total++;
      if (outs !== exp_b[i]) begin
        bad++;
        $display("FAIL redir_reload[%0d] got=%b want=%b", i, outs, exp_b[i]);
      end
      tick();
    end
    idle();
    total++;
    if (stall_cycles !== 32'd1) begin
      bad++;
      $display("FAIL redir_cnt got=%0d want=1", stall_cycles);
    end
  endtask

  task automatic test_mem_wait();
    // {dmem_req, dmem_ready, ex_redirect} per cycle
    logic [2:0] in_t  [0:11];
    logic [5:0] exp_t [0:11];
    in_t  = '{3'b101, 3'b101, 3'b111, 3'b000, 3'b000, 3'b000,
              3'b001, 3'b100, 3'b100, 3'b000, 3'b000, 3'b000};
    exp_t = '{6'b000001, 6'b000001, 6'b111100, 6'b111000, 6'b111000, 6'b110000,
              6'b111100, 6'b000001, 6'b000001, 6'b111000, 6'b111000, 6'b110000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dmem_req   = 1'b1;
      dmem_ready = 1'b0;
      #2;
      total++;
      if (outs !== 6'b000001) begin
        bad++;
        $display("FAIL mw_hold[%0d] got=%b want=%b", i, outs, 6'b000001);
      end
      tick();
    end
    dmem_ready = 1'b1;
    #2;
    total++;
    if (outs !== 6'b110000) begin
      bad++;
      $display("FAIL mw_release got=%b want=%b", outs, 6'b110000);
    end
    tick();
    idle();
    total++;
    if (stall_cycles !== 32'd4) begin
      bad++;
      $display("FAIL mw_cnt got=%0d want=4", stall_cycles);
    end
    do_reset();
    for (int i = 0; i < 12; i++) begin
      idle();
      dmem_req    = in_t[i][2];
      dmem_ready  = in_t[i][1];
      ex_redirect = in_t[i][0];
      #2;
      total++;
      if (outs !== exp_t[i]) begin
        bad++;
        $display("FAIL mw_redir[%0d] got=%b want=%b", i, outs, exp_t[i]);
      end
      tick();
    end
    idle();
    total++;
    if (stall_cycles !== 32'd4) begin
      bad++;
      $display("FAIL mw_redir_cnt got=%0d want=4", stall_cycles);
    end
    total++;
    if (mem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL mw_no_timeout got=%b want=0", mem_timeout);
    end
  endtask

  task automatic test_timeout();
    logic exp_to [0:4];
    exp_to = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dmem_req   = 1'b1;
      dmem_ready = 1'b0;
      #2;
      total++;
      if (mem_timeout !== exp_to[i]) begin
        bad++;
        $display("FAIL to_wait[%0d] got=%b want=%b", i, mem_timeout, exp_to[i]);
      end
      tick();
    end
    dmem_ready = 1'b1;
    #2;
    total++;
    if (outs !== 6'b110000) begin
      bad++;
      $display("FAIL to_release got=%b want=%b", outs, 6'b110000);
    end
    tick();
    idle();
    tick();
    total++;
    if (mem_timeout !== 1'b1) begin
      bad++;
      $display("FAIL to_sticky got=%b want=1", mem_timeout);
    end
    total++;
    if (stall_cycles !== 32'd5) begin
      bad++;
      $display("FAIL to_cnt got=%0d want=5", stall_cycles);
    end
  endtask

  task automatic test_reset_mid();
    // reset in the middle of a redirect
    do_reset();
    ex_redirect = 1'b1;
    tick();
    idle();
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (outs !== 6'b001100) begin
      bad++;
      $display("FAIL mid_redir_rst got=%b want=%b", outs, 6'b001100);
    end
    rst_n = 1'b1;
    tick();
    #2;
    total++;
    if (outs !== 6'b110000) begin
      bad++;
      $display("FAIL mid_redir_post got=%b want=%b", outs, 6'b110000);
    end
    tick();
    set_lu();
    #2;
    total++;
    if (outs !== 6'b000010) begin
      bad++;
      $display("FAIL mid_redir_run got=%b want=%b", outs, 6'b000010);
    end
    tick();
    idle();
    total++;
    if (stall_cycles !== 32'd1) begin
      bad++;
      $display("FAIL mid_redir_cnt got=%0d want=1", stall_cycles);
    end
    // reset in the middle of a memory wait that already timed out
    do_reset();
    dmem_req = 1'b1;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (outs !== 6'b001100) begin
      bad++;
      $display("FAIL mid_wait_rst got=%b want=%b", outs, 6'b001100);
    end
    total++;
    if (mem_timeout !== 1'b0 || stall_cycles !== 32'd0) begin
      bad++;
      $display("FAIL mid_wait_clear got=%b/%0d want=0/0", mem_timeout, stall_cycles);
    end
    idle();
    rst_n = 1'b1;
    tick();
    #2;
    total++;
    if (outs !== 6'b110000) begin
      bad++;
      $display("FAIL mid_wait_post got=%b want=%b", outs, 6'b110000);
    end
    tick();
    dmem_req = 1'b1;
    tick();
    tick();
    dmem_ready = 1'b1;
    tick();
    idle();
    tick();
    total++;
    if (mem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL mid_wait_wcnt got=%b want=0", mem_timeout);
    end
    total++;
    if (stall_cycles !== 32'd2) begin
      bad++;
      $display("FAIL mid_wait_cnt got=%0d want=2", stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
